history_buffer: RTL and testbench

HISTORY_BUFFER -- requirements
Module: history_buffer

---
 rtl/history_buffer.sv | 183 ++++++++++++++++++
 tb/tb_history_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/history_buffer.sv
// Undo/redo history ring of (x, y, colour) entries with an edge-detected command
// interface and a ready/valid held restore port. DEPTH must be a power of two >= 2.
module history_buffer #(
  parameter int DEPTH = 8,
  parameter int X_W   = 8,
  parameter int Y_W   = 8,
  parameter int C_W   = 3,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           save,
  input  logic           undo,
  input  logic           redo,
  input  logic           clear,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic [C_W-1:0] color_in,
  input  logic           restore_ready,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [C_W-1:0] color_out,
  output logic           restore_valid,
  output logic           restore_is_redo,
  output logic           can_undo,
  output logic           can_redo,
  output logic [CW-1:0]  count,
  output logic [CW-1:0]  redo_cnt,
  output logic           overflow,
  output logic           drop
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = X_W + Y_W + C_W;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  // Previous-cycle samples of the command levels for rising-edge detection
  logic save_p_q, undo_p_q, redo_p_q, clear_p_q;
  logic save_e, undo_e, redo_e, clear_e;

  ptr_t wr_ptr_q, wr_ptr_d;
  cnt_t count_q, count_d;
  cnt_t redo_q, redo_d;
  logic valid_q, valid_d;
  logic is_redo_q, is_redo_d;
  logic overflow_q, overflow_d;
  logic drop_q, drop_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [C_W-1:0] c_q, c_d;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] rd_data;

  logic do_clear, do_save, do_undo, do_redo;
  logic stalled;
  cnt_t live;
  ptr_t w_idx, u_idx, rd_idx;

  assign save_e  = save  & ~save_p_q;
  assign undo_e  = undo  & ~undo_p_q;
  assign redo_e  = redo  & ~redo_p_q;
  assign clear_e = clear & ~clear_p_q;

  assign stalled  = valid_q & ~restore_ready;
  assign can_undo = (count_q > redo_q);
  assign can_redo = (redo_q != '0);
  assign live     = count_q - redo_q;

  // Save target and redo source coincide: the slot just past the live history
  assign w_idx  = wr_ptr_q - ptr_t'(redo_q);
  assign u_idx  = w_idx - ptr_t'(1);
  assign rd_idx = do_redo ? w_idx : u_idx;

  always_comb begin
    do_clear = 1'b0;
    do_save  = 1'b0;
    do_undo  = 1'b0;
    do_redo  = 1'b0;
    drop_d   = 1'b0;
    if (clear_e) begin
      do_clear = 1'b1;
      drop_d   = save_e | undo_e | redo_e;
    end else if (stalled) begin
      drop_d = save_e | undo_e | redo_e;
    end else if (save_e) begin
      do_save = 1'b1;
      drop_d  = undo_e | redo_e;
    end else if (undo_e) begin
      do_undo = can_undo;
      drop_d  = ~can_undo | redo_e;
    end else if (redo_e) begin
      do_redo = can_redo;
      drop_d  = ~can_redo;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    redo_d     = redo_q;
    is_redo_d  = is_redo_q;
    overflow_d = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    c_d        = c_q;
    valid_d    = valid_q & ~restore_ready;
    if (do_clear) begin
      wr_ptr_d = '0;
      count_d  = '0;
      redo_d   = '0;
      valid_d  = 1'b0;
    end else if (do_save) begin
      wr_ptr_d   = w_idx + ptr_t'(1);
      redo_d     = '0;
      overflow_d = (live == DEPTH_C);
      count_d    = (live == DEPTH_C) ? DEPTH_C : live + cnt_t'(1);
    end else if (do_undo || do_redo) begin
      {x_d, y_d, c_d} = rd_data;
      valid_d   = 1'b1;
      is_redo_d = do_redo;
      redo_d    = do_redo ? redo_q - cnt_t'(1) : redo_q + cnt_t'(1);
    end
  end

  // Entry storage is deliberately unreset; count = 0 hides stale contents
  always_ff @(posedge clk) begin
    if (do_save) begin
      mem_q[w_idx] <= {x_in, y_in, color_in};
    end
  end

  assign rd_data = mem_q[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      save_p_q   <= 1'b0;
      undo_p_q   <= 1'b0;
      redo_p_q   <= 1'b0;
      clear_p_q  <= 1'b0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      redo_q     <= '0;
      valid_q    <= 1'b0;
      is_redo_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      c_q        <= '0;
    end else begin
      save_p_q   <= save;
      undo_p_q   <= undo;
      redo_p_q   <= redo;
      clear_p_q  <= clear;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      redo_q     <= redo_d;
      valid_q    <= valid_d;
      is_redo_q  <= is_redo_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      x_q        <= x_d;
      y_q        <= y_d;
      c_q        <= c_d;
    end
  end

  assign x_out           = x_q;
  assign y_out           = y_q;
  assign color_out       = c_q;
  assign restore_valid   = valid_q;
  assign restore_is_redo = is_redo_q;
  assign count           = count_q;
  assign redo_cnt        = redo_q;
  assign overflow        = overflow_q;
  assign drop            = drop_q;

endmodule

// File: tb/tb_history_buffer.sv
// Scoreboard bench for history_buffer: expected restores are queued when an
// undo/redo is issued and compared when the DUT presents the restored entry.
module tb_history_buffer;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          save = 1'b0, undo = 1'b0, redo = 1'b0, clear = 1'b0;
  logic [7:0]    x_in = '0, y_in = '0;
  logic [2:0]    color_in = '0;
  logic          restore_ready = 1'b1;
  logic [7:0]    x_out, y_out;
  logic [2:0]    color_out;
  logic          restore_valid, restore_is_redo, can_undo, can_redo;
  logic [CW-1:0] count, redo_cnt;
  logic          overflow, drop;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
    logic       r;
  } exp_t;
  exp_t sb_q[$];

  history_buffer #(.DEPTH(DEPTH), .X_W(8), .Y_W(8), .C_W(3)) dut (
    .clk(clk), .rst(rst),
    .save(save), .undo(undo), .redo(redo), .clear(clear),
    .x_in(x_in), .y_in(y_in), .color_in(color_in),
    .restore_ready(restore_ready),
    .x_out(x_out), .y_out(y_out), .color_out(color_out),
    .restore_valid(restore_valid), .restore_is_redo(restore_is_redo),
    .can_undo(can_undo), .can_redo(can_redo),
    .count(count), .redo_cnt(redo_cnt),
    .overflow(overflow), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command cycle: levels high for one edge, then low again
  task automatic cmd(input logic s, input logic u, input logic r, input logic c);
    save = s; undo = u; redo = r; clear = c;
    tick();
    save = 1'b0; undo = 1'b0; redo = 1'b0; clear = 1'b0;
  endtask

  task automatic do_save(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c,
                         input logic exp_ovf);
    x_in = x; y_in = y; color_in = c;
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check($sformatf("save(%0d,%0d,%0d) overflow", x, y, c), 32'(overflow), 32'(exp_ovf));
    tick();
  endtask

  task automatic collect(input string tag);
    exp_t e;
    check({tag, " restore_valid"}, 32'(restore_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, " xyc"}, {13'd0, x_out, y_out, color_out}, {13'd0, e.x, e.y, e.c});
      check({tag, " is_redo"}, 32'(restore_is_redo), 32'(e.r));
    end
  endtask

  task automatic exp_restore(input logic u, input logic [7:0] x, input logic [7:0] y,
                             input logic [2:0] c, input string tag);
    exp_t e;
    e.x = x; e.y = y; e.c = c; e.r = ~u;
    sb_q.push_back(e);
    cmd(1'b0, u, ~u, 1'b0);
    collect(tag);
  endtask

  task automatic exp_drop_undo(input string tag);
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    check({tag, " drop"}, 32'(drop), 32'd1);
    check({tag, " can_undo"}, 32'(can_undo), 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset count", 32'(count), 32'd0);
    check("reset redo_cnt", 32'(redo_cnt), 32'd0);
    check("reset valid", 32'(restore_valid), 32'd0);
    check("reset xyc", {13'd0, x_out, y_out, color_out}, 32'd0);
    check("reset flags", {28'd0, can_undo, can_redo, overflow, drop}, 32'd0);

    // Scenario 1
    do_save(8'd1, 8'd2, 3'd3, 1'b0);
    do_save(8'd4, 8'd5, 3'd6, 1'b0);
    exp_restore(1'b1, 8'd4, 8'd5, 3'd6, "s1 undo");
    check("s1 redo_cnt", 32'(redo_cnt), 32'd1);
    check("s1 count", 32'(count), 32'd2);
    tick();
    check("s1 valid released", 32'(restore_valid), 32'd0);

    // Scenario 2
    exp_restore(1'b1, 8'd1, 8'd2, 3'd3, "s2 undo2");
    tick();
    exp_drop_undo("s2 undo3");
    check("s2 drop clears", 32'(drop), 32'd0);
    exp_restore(1'b0, 8'd1, 8'd2, 3'd3, "s2 redo");
    check("s2 redo_cnt", 32'(redo_cnt), 32'd1);
    tick();

    // Scenario 3
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 10; k++) begin
      do_save(8'(k), 8'(k), 3'(k), k >= 8);
    end
    check("s3 count", 32'(count), 32'd8);
    for (int k = 9; k >= 2; k--) begin
      exp_restore(1'b1, 8'(k), 8'(k), 3'(k), $sformatf("s3 undo k=%0d", k));
      tick();
    end
    exp_drop_undo("s3 undo9");

    // Scenario 4
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    do_save(8'd10, 8'd11, 3'd1, 1'b0);
    do_save(8'd20, 8'd21, 3'd2, 1'b0);
    do_save(8'd30, 8'd31, 3'd3, 1'b0);
    exp_restore(1'b1, 8'd30, 8'd31, 3'd3, "s4 undoC");
    tick();
    exp_restore(1'b1, 8'd20, 8'd21, 3'd2, "s4 undoB");
    tick();
    do_save(8'd40, 8'd41, 3'd4, 1'b0);
    check("s4 count", 32'(count), 32'd2);
    check("s4 redo_cnt", 32'(redo_cnt), 32'd0);
    check("s4 can_redo", 32'(can_redo), 32'd0);
    exp_restore(1'b1, 8'd40, 8'd41, 3'd4, "s4 undoD");
    tick();
    exp_restore(1'b1, 8'd10, 8'd11, 3'd1, "s4 undoA");
    tick();

    // Scenario 5
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    do_save(8'd5, 8'd6, 3'd7, 1'b0);
    do_save(8'd8, 8'd9, 3'd1, 1'b0);
    restore_ready = 1'b0;
    exp_restore(1'b1, 8'd8, 8'd9, 3'd1, "s5 undo");
    tick();
    check("s5 held valid", 32'(restore_valid), 32'd1);
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    check("s5 stalled drop", 32'(drop), 32'd1);
    check("s5 held xyc", {13'd0, x_out, y_out, color_out}, {13'd0, 8'd8, 8'd9, 3'd1});
    check("s5 redo_cnt unchanged", 32'(redo_cnt), 32'd1);
    restore_ready = 1'b1;
    tick();
    check("s5 valid falls", 32'(restore_valid), 32'd0);

    // Scenario 6
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    x_in = 8'd7; y_in = 8'd7; color_in = 3'd7;
    cmd(1'b1, 1'b1, 1'b0, 1'b0);
    check("s6 same-cycle drop", 32'(drop), 32'd1);
    check("s6 save won count", 32'(count), 32'd1);
    check("s6 no restore", 32'(restore_valid), 32'd0);
    tick();
    restore_ready = 1'b0;
    exp_restore(1'b1, 8'd7, 8'd7, 3'd7, "s6 undo");
    tick();
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    check("s6 clear count", 32'(count), 32'd0);
    check("s6 clear valid", 32'(restore_valid), 32'd0);
    check("s6 clear keeps xyc", {13'd0, x_out, y_out, color_out}, {13'd0, 8'd7, 8'd7, 3'd7});
    tick();

    // Reset while a restore is held
    do_save(8'd3, 8'd3, 3'd3, 1'b0);
    exp_restore(1'b1, 8'd3, 8'd3, 3'd3, "rst undo");
    #2;
    rst = 1'b1;
    #1;
    check("async rst valid", 32'(restore_valid), 32'd0);
    check("async rst count", 32'(count), 32'd0);
    tick();
    rst = 1'b0;
    restore_ready = 1'b1;
    tick();

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
